// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult
//   Unsigned shift-and-add sequential multiplier. A start accepted in IDLE
//   captures a and b. Each RUN cycle then performs one partial-product step.
//   After WIDTH steps the 2*WIDTH-bit result is loaded into a held product
//   register, and done pulses for one cycle.
//
// Ports
//   clk      in   1        rising-edge clock
//   aclr_n   in   1        asynchronous active-low clear of all state
//   start    in   1        operation request, sampled only in IDLE
//   a        in   WIDTH    multiplicand, captured on accepted start
//   b        in   WIDTH    multiplier, captured on accepted start
//   busy     out  1        high while an operation is running
//   done     out  1        one-cycle pulse; product is valid
//   product  out  2*WIDTH  last completed result, held until next completion

module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               aclr_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W  = WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    acc_q,   acc_d;
  logic [WIDTH-1:0]    mplr_q,  mplr_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;

  logic [WIDTH-1:0]    addend_c;
  logic [SUM_W-1:0]    sum_c;
  logic                last_step_c;

  // Partial-product adder; the extra bit keeps the carry for the acc MSB.
  always_comb begin
    addend_c    = mplr_q[0] ? mcand_q : '0;
    sum_c       = {1'b0, acc_q} + {1'b0, addend_c};
    last_step_c = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = a;
          mplr_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // {acc,mplr} <= {sum,mplr} >> 1
        acc_d  = sum_c[SUM_W-1:1];
        mplr_d = {sum_c[0], mplr_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_step_c) begin
          // Capture the post-shift value so product never shows partial sums.
          product_d = {sum_c, mplr_q[WIDTH-1:1]};
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the next-state decode.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult
//   Directed, table-driven bench for seq_shift_add_mult with WIDTH=4.
//   Inputs are driven and outputs sampled on the falling clock edge.

module tb_seq_shift_add_mult;

  localparam int unsigned W  = 4;
  localparam int unsigned NV = 9;
  localparam int unsigned TMO = 20;

  logic           clk;
  logic           aclr_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs [NV];

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One complete operation with a single-cycle start pulse.
  task automatic run_one(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2*W-1:0] vexp, input string tag);
    int n;
    bit excl_ok;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb;
    n = 0;
    excl_ok = 1'b1;
    while (busy && n < TMO) begin
      if (done) excl_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(W));
    check({tag, " busy_done_exclusive"}, 32'(excl_ok), 32'd1);
    check({tag, " done_high"}, 32'(done), 32'd1);
    check({tag, " product"}, 32'(product), 32'(vexp));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " product_held"}, 32'(product), 32'(vexp));
  endtask

  initial begin
    int first_done;
    int second_done;
    int k;
    int n_done;
    logic [2*W-1:0] prod_at [2];

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  exp: 8'd15};
    vecs[1] = '{a: 4'd15, b: 4'd15, exp: 8'd225};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  exp: 8'd0};
    vecs[3] = '{a: 4'd9,  b: 4'd0,  exp: 8'd0};
    vecs[4] = '{a: 4'd4,  b: 4'd4,  exp: 8'd16};
    vecs[5] = '{a: 4'd1,  b: 4'd15, exp: 8'd15};
    vecs[6] = '{a: 4'd15, b: 4'd1,  exp: 8'd15};
    vecs[7] = '{a: 4'd10, b: 4'd12, exp: 8'd120};
    vecs[8] = '{a: 4'd8,  b: 4'd8,  exp: 8'd64};

    aclr_n = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    aclr_n = 1'b1;

    for (int i = 0; i < int'(NV); i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Start held high: back-to-back operations, operands changed after accept.
    @(negedge clk);
    a = 4'd7; b = 4'd6; start = 1'b1;
    first_done  = -1;
    second_done = -1;
    prod_at[0]  = '0;
    prod_at[1]  = '0;
    for (k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a = 4'd2; b = 4'd3;
      end
      if (done) begin
        if (first_done < 0) begin
          first_done = k;
          prod_at[0] = product;
        end else if (second_done < 0) begin
          second_done = k;
          prod_at[1] = product;
        end
      end
    end
    start = 1'b0;
    check("b2b first_done_edge", 32'(first_done), 32'd5);
    check("b2b second_done_edge", 32'(second_done), 32'd11);
    check("b2b first_product", 32'(prod_at[0]), 32'd42);
    check("b2b second_product", 32'(prod_at[1]), 32'd6);
    k = 0;
    while ((busy || done) && k < int'(TMO)) begin
      k++;
      @(negedge clk);
    end
    check("b2b drain_idle", 32'(busy | done), 32'd0);

    // Start pulsed during RUN is ignored.
    @(negedge clk);
    a = 4'd11; b = 4'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int j = 0; j < 12; j++) begin
      if (done) begin
        n_done++;
        check("ignore_start product", 32'(product), 32'd143);
      end
      @(negedge clk);
    end
    check("ignore_start done_count", 32'(n_done), 32'd1);

    // Asynchronous clear mid-run after two steps.
    @(negedge clk);
    a = 4'd13; b = 4'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_clear busy", 32'(busy), 32'd1);
    #1 aclr_n = 1'b0;
    #1;
    check("clear busy", 32'(busy), 32'd0);
    check("clear done", 32'(done), 32'd0);
    check("clear product", 32'(product), 32'd0);
    @(negedge clk);
    aclr_n = 1'b1;
    n_done = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("clear no_resume", 32'(n_done), 32'd0);
    run_one(4'd4, 4'd4, 8'd16, "post_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
